// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl
// Generation sequencer for a Game-of-Life cell array. It seeds the array,
// then steps each generation through the 8-phase cell evaluation sequence,
// either one generation at a time or free-running. Free-running stops when
// run drops or when an optional generation target is reached.
//
// Parameters
//   GEN_W     width of the generation counter and of the stop target
//   SEED_CYC  cycles cell_nrst is held low per load (1..15)
//
// Ports
//   clk        single clock, all logic on the rising edge
//   nrst       asynchronous active-low reset
//   load       (re)seed request; aborts any activity, highest priority
//   run        level: free-run generations while high
//   step       pulse: advance exactly one generation
//   stop_gen   halt target (0 = no target), sampled at each boundary
//   cell_nrst  registered synchronous reset to the cells (seed loads while low)
//   cell_en    registered clock-enable to the cells
//   phase      current cell evaluation phase 0..7
//   gen_count  generations completed since the last load
//   gen_done   one-cycle pulse after each completed generation
//   busy       high while seeding or running
//   halted     sticky: the stop target was reached
//   ovf        sticky: gen_count wrapped
module life_gen_ctrl #(
  parameter int GEN_W    = 16,
  parameter int SEED_CYC = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [GEN_W-1:0] stop_gen,
  output logic             cell_nrst,
  output logic             cell_en,
  output logic [2:0]       phase,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_done,
  output logic             busy,
  output logic             halted,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [3:0] SEED_LAST = 4'(SEED_CYC - 1);

  state_t           state, state_nxt;
  logic [3:0]       seed_cnt, seed_cnt_nxt;
  logic             by_step, by_step_nxt;
  logic [2:0]       phase_nxt;
  logic [GEN_W-1:0] gen_count_nxt;
  logic [GEN_W-1:0] gen_inc;
  logic             gen_done_nxt;
  logic             halted_nxt;
  logic             ovf_nxt;
  logic             target_hit;
  logic             cell_nrst_nxt;
  logic             cell_en_nxt;
  logic             busy_nxt;

  // State and every output are registered together, so the outputs always
  // describe the state the controller is currently in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      seed_cnt  <= '0;
      by_step   <= 1'b0;
      phase     <= '0;
      gen_count <= '0;
      gen_done  <= 1'b0;
      halted    <= 1'b0;
      ovf       <= 1'b0;
      cell_nrst <= 1'b0;
      cell_en   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      seed_cnt  <= seed_cnt_nxt;
      by_step   <= by_step_nxt;
      phase     <= phase_nxt;
      gen_count <= gen_count_nxt;
      gen_done  <= gen_done_nxt;
      halted    <= halted_nxt;
      ovf       <= ovf_nxt;
      cell_nrst <= cell_nrst_nxt;
      cell_en   <= cell_en_nxt;
      busy      <= busy_nxt;
    end
  end

  assign gen_inc    = gen_count + 1'b1;
  // Equality only: after a target stop, resuming run passes the target and
  // will not stop on it again until the counter wraps around.
  assign target_hit = (stop_gen != '0) && (gen_inc == stop_gen);

  // Next-state logic. load overrides everything and restarts seeding, which
  // throws away a partial generation without raising gen_done.
  always_comb begin
    state_nxt     = state;
    seed_cnt_nxt  = seed_cnt;
    by_step_nxt   = by_step;
    phase_nxt     = phase;
    gen_count_nxt = gen_count;
    gen_done_nxt  = 1'b0;
    halted_nxt    = halted;
    ovf_nxt       = ovf;

    if (load) begin
      state_nxt     = SEED;
      seed_cnt_nxt  = '0;
      phase_nxt     = '0;
      gen_count_nxt = '0;
      halted_nxt    = 1'b0;
      ovf_nxt       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        SEED: begin
          if (seed_cnt == SEED_LAST) begin
            state_nxt = READY;
          end else begin
            seed_cnt_nxt = seed_cnt + 4'd1;
          end
        end
        READY: begin
          // run and step together means free-run
          if (run || step) begin
            state_nxt   = RUN;
            by_step_nxt = !run;
            phase_nxt   = '0;
          end
        end
        RUN: begin
          // Phase 7 is the generation boundary; only here can RUN end, so
          // dropping run mid-generation still lets the cells finish.
          if (phase == 3'd7) begin
            gen_count_nxt = gen_inc;
            gen_done_nxt  = 1'b1;
            phase_nxt     = '0;
            if (&gen_count) begin
              ovf_nxt = 1'b1;
            end
            if (target_hit) begin
              halted_nxt = 1'b1;
            end
            if (by_step || !run || target_hit) begin
              state_nxt = READY;
            end
          end else begin
            phase_nxt = phase + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Cell controls derived from the state being entered, so they line up
  // with that state once registered.
  always_comb begin
    cell_nrst_nxt = (state_nxt == READY) || (state_nxt == RUN);
    cell_en_nxt   = (state_nxt == SEED)  || (state_nxt == RUN);
    busy_nxt      = (state_nxt == SEED)  || (state_nxt == RUN);
  end

endmodule
